// File: rtl/uart_tx_sched_if.sv
// Register bus between the transmit scheduler (master) and the UART (slave).
// The UART answers a read strobe with bus_dout one cycle later.
interface uart_tx_sched_if;
    logic       bus_wren;
    logic       bus_rden;
    logic [2:0] bus_addr;
    logic [7:0] bus_din;
    logic [7:0] bus_dout;

    modport master (
        output bus_wren, bus_rden, bus_addr, bus_din,
        input  bus_dout
    );

    modport slave (
        input  bus_wren, bus_rden, bus_addr, bus_din,
        output bus_dout
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler that pushes bytes from four requesters into a UART,
// polling the FIFO-full flag before every write and reprogramming the baud period.
module uart_tx_sched #(
    parameter logic [7:0] PERIOD  = 8'h1A,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_period,
    output logic [3:0]  gnt,
    output logic        drop,
    output logic        busy,
    uart_tx_sched_if.master bus
);

    typedef enum logic [2:0] {INIT, IDLE, CFG, POLL, CHECK, WRITE} state_t;

    localparam logic [2:0] ADDR_PERIOD = 3'b000;
    localparam logic [2:0] ADDR_TX     = 3'b001;
    localparam logic [2:0] ADDR_IDLE   = 3'b010;
    localparam logic [2:0] ADDR_CTRL   = 3'b011;

    state_t     state, state_nxt;
    logic [7:0] period_reg;
    logic       cfg_pend;
    logic [1:0] rr_ptr;
    logic [1:0] sel;
    logic [7:0] poll_cnt;
    logic [1:0] win;
    logic       win_ok;
    logic       drop_nxt;

    // First active requester at or after rr_ptr, wrapping 3 -> 0.
    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        win    = rr_ptr;
        win_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!win_ok && req[rr_ptr + 2'(i)]) begin
                win    = rr_ptr + 2'(i);
                win_ok = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        drop_nxt  = 1'b0;
        case (state)
            INIT:  state_nxt = IDLE;
            // A cfg_we arriving in IDLE is served at once, ahead of any request.
            IDLE: begin
                if (cfg_pend || cfg_we) state_nxt = CFG;
                else if (win_ok)        state_nxt = POLL;
            end
            CFG:   state_nxt = IDLE;
            POLL:  state_nxt = req[sel] ? CHECK : IDLE;
            CHECK: begin
                if (!req[sel])              state_nxt = IDLE;
                else if (!bus.bus_dout[0])  state_nxt = WRITE;
                else if (poll_cnt == TIMEOUT) begin
                    state_nxt = IDLE;
                    drop_nxt  = 1'b1;
                end
                else                        state_nxt = POLL;
            end
            WRITE: state_nxt = IDLE;
            default: state_nxt = INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            period_reg <= PERIOD;
            cfg_pend <= 1'b0;
            rr_ptr   <= 2'd0;
            sel      <= 2'd0;
            poll_cnt <= 8'd0;
        end else begin
            state <= state_nxt;
            if (cfg_we) period_reg <= cfg_period;
            if (state == IDLE && state_nxt == CFG) cfg_pend <= 1'b0;
            else if (cfg_we)                       cfg_pend <= 1'b1;
            if (state == IDLE && state_nxt == POLL) begin
                sel      <= win;
                poll_cnt <= 8'd0;
            end
            if (state == CHECK && state_nxt == POLL) poll_cnt <= poll_cnt + 8'd1;
            if (state == WRITE) begin
                rr_ptr   <= sel + 2'd1;
                poll_cnt <= 8'd0;
            end
        end
    end

    // Outputs are registered from the state being entered, so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt          <= 4'b0000;
            drop         <= 1'b0;
            busy         <= 1'b1;
            bus.bus_wren <= 1'b0;
            bus.bus_rden <= 1'b0;
            bus.bus_addr <= ADDR_IDLE;
            bus.bus_din  <= 8'h00;
        end else if (state == INIT) begin
            gnt          <= 4'b0000;
            drop         <= 1'b0;
            busy         <= 1'b1;
            bus.bus_wren <= 1'b1;
            bus.bus_rden <= 1'b0;
            bus.bus_addr <= ADDR_PERIOD;
            bus.bus_din  <= period_reg;
        end else begin
            gnt          <= (state_nxt == WRITE) ? (4'b0001 << sel) : 4'b0000;
            drop         <= drop_nxt;
            busy         <= (state_nxt != IDLE);
            bus.bus_wren <= (state_nxt == CFG) || (state_nxt == WRITE);
            bus.bus_rden <= (state_nxt == POLL);
            case (state_nxt)
                CFG: begin
                    bus.bus_addr <= ADDR_PERIOD;
                    bus.bus_din  <= cfg_we ? cfg_period : period_reg;
                end
                POLL:  bus.bus_addr <= ADDR_CTRL;
                WRITE: begin
                    bus.bus_addr <= ADDR_TX;
                    bus.bus_din  <= req_data[{sel, 3'b000} +: 8];
                end
                default: bus.bus_addr <= ADDR_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: a default instance plus a TIMEOUT=2 instance
// whose UART reports a permanently full FIFO.
module tb_uart_tx_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = 4'b0000;
    logic [3:0]  req2 = 4'b0000;
    logic [31:0] req_data = 32'h0;
    logic        cfg_we = 1'b0;
    logic [7:0]  cfg_period = 8'h00;
    logic [3:0]  gnt, gnt2;
    logic        drop, drop2, busy, busy2;

    int n_cmp = 0;
    int n_err = 0;
    int full_left = 0;

    uart_tx_sched_if bus();
    uart_tx_sched_if bus2();

    uart_tx_sched u_dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .cfg_we(cfg_we), .cfg_period(cfg_period),
        .gnt(gnt), .drop(drop), .busy(busy), .bus(bus)
    );

    uart_tx_sched #(.TIMEOUT(8'd2)) u_dut_to (
        .clk(clk), .reset(reset), .req(req2), .req_data(req_data),
        .cfg_we(1'b0), .cfg_period(8'h00),
        .gnt(gnt2), .drop(drop2), .busy(busy2), .bus(bus2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge. The UART model answers a poll
    // with "full" while full_left is non-zero and holds the answer until the next poll.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.bus_rden) begin
            bus.bus_dout = {7'b0, full_left != 0};
            if (full_left != 0) full_left--;
        end
    endtask

    task automatic wait_gnt(input int budget, output int cyc, output logic [3:0] g, output int polls);
        cyc = -1;
        g = 4'b0000;
        polls = 0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (bus.bus_rden) polls++;
            if (gnt != 4'b0000) begin
                cyc = i;
                g = gnt;
                break;
            end
        end
    endtask

    logic [3:0] rr_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [7:0] rr_b [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};

    initial begin
        int cyc;
        int polls;
        int polls2;
        int drop_cyc;
        int drop_cnt;
        int wr_tx;
        int ngnt2;
        logic [3:0] g;

        bus.bus_dout = 8'h00;
        bus2.bus_dout = 8'h01;

        // Reset values
        tick(); tick();
        check("rst_busy", busy, 1);
        check("rst_wren", bus.bus_wren, 0);
        check("rst_rden", bus.bus_rden, 0);
        check("rst_addr", bus.bus_addr, 3'b010);
        check("rst_din", bus.bus_din, 8'h00);
        check("rst_gnt", gnt, 4'b0000);
        check("rst_drop", drop, 0);

        // Init write of the default period, then idle
        reset = 1'b0;
        tick();
        check("init_wren", bus.bus_wren, 1);
        check("init_addr", bus.bus_addr, 3'b000);
        check("init_din", bus.bus_din, 8'h1A);
        check("init_busy", busy, 1);
        tick();
        check("idle_busy", busy, 0);
        check("idle_wren", bus.bus_wren, 0);
        check("idle_rden", bus.bus_rden, 0);
        check("idle_addr", bus.bus_addr, 3'b010);
        check("idle_busy2", busy2, 0);

        // All four requesting: 0,1,2,3,0 four cycles apart
        req_data = 32'h44332211;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(10, cyc, g, polls);
            check("rr_gnt", g, rr_g[k]);
            check("rr_gap", cyc, (k == 0) ? 3 : 4);
            check("rr_din", bus.bus_din, rr_b[k]);
            check("rr_addr", bus.bus_addr, 3'b001);
        end
        req = 4'b0000;
        tick();
        check("rr_idle", busy, 0);

        // Requester 1 withdraws during CHECK; it keeps priority afterwards
        req = 4'b0010;
        tick();
        check("ab_poll_rden", bus.bus_rden, 1);
        tick();
        check("ab_chk_rden", bus.bus_rden, 0);
        req = 4'b0000;
        tick();
        check("ab_gnt", gnt, 4'b0000);
        check("ab_wren", bus.bus_wren, 0);
        check("ab_busy", busy, 0);
        req_data = 32'h00BBAA00;
        req = 4'b0110;
        wait_gnt(10, cyc, g, polls);
        check("ab_next_gnt", g, 4'b0010);
        check("ab_next_cyc", cyc, 3);
        check("ab_next_din", bus.bus_din, 8'hAA);
        req = 4'b0000;
        tick();

        // Single uncontended transfer, cycle by cycle
        req_data = 32'h00000055;
        req = 4'b0001;
        tick();
        check("s_rden", bus.bus_rden, 1);
        check("s_addr", bus.bus_addr, 3'b011);
        check("s_wren", bus.bus_wren, 0);
        tick();
        check("s_chk_rden", bus.bus_rden, 0);
        check("s_chk_wren", bus.bus_wren, 0);
        check("s_chk_gnt", gnt, 4'b0000);
        tick();
        check("s_wr_wren", bus.bus_wren, 1);
        check("s_wr_addr", bus.bus_addr, 3'b001);
        check("s_wr_din", bus.bus_din, 8'h55);
        check("s_wr_gnt", gnt, 4'b0001);
        check("s_wr_rden", bus.bus_rden, 0);
        req = 4'b0000;
        tick();
        check("s_end_busy", busy, 0);
        check("s_end_gnt", gnt, 4'b0000);

        // FIFO full for three polls, then free
        full_left = 3;
        req_data = 32'h000000A5;
        req = 4'b0001;
        wait_gnt(20, cyc, g, polls);
        check("fp_gnt", g, 4'b0001);
        check("fp_cyc", cyc, 9);
        check("fp_polls", polls, 4);
        check("fp_din", bus.bus_din, 8'hA5);
        req = 4'b0000;
        tick();

        // Period reprogram wins over a simultaneous request
        req_data = 32'h00770000;
        req = 4'b0100;
        cfg_we = 1'b1;
        cfg_period = 8'h0D;
        tick();
        cfg_we = 1'b0;
        check("cfg_wren", bus.bus_wren, 1);
        check("cfg_addr", bus.bus_addr, 3'b000);
        check("cfg_din", bus.bus_din, 8'h0D);
        check("cfg_rden", bus.bus_rden, 0);
        tick();
        check("cfg_gap_rden", bus.bus_rden, 0);
        check("cfg_gap_wren", bus.bus_wren, 0);
        tick();
        check("cfg_poll_rden", bus.bus_rden, 1);
        wait_gnt(5, cyc, g, polls);
        check("cfg_gnt", g, 4'b0100);
        check("cfg_gnt_cyc", cyc, 2);
        check("cfg_gnt_din", bus.bus_din, 8'h77);
        req = 4'b0000;
        tick();

        // TIMEOUT=2 instance with a permanently full FIFO: drop after the third CHECK
        polls2 = 0;
        drop_cyc = -1;
        drop_cnt = 0;
        wr_tx = 0;
        ngnt2 = 0;
        req2 = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus2.bus_rden) polls2++;
            if (bus2.bus_wren && bus2.bus_addr == 3'b001) wr_tx++;
            if (gnt2 != 4'b0000) ngnt2++;
            if (drop2) begin
                drop_cnt++;
                if (drop_cyc < 0) drop_cyc = i;
                req2 = 4'b0000;
            end
        end
        check("to_polls", polls2, 3);
        check("to_drop_cyc", drop_cyc, 7);
        check("to_drop_cnt", drop_cnt, 1);
        check("to_tx_writes", wr_tx, 0);
        check("to_gnt", ngnt2, 0);
        check("to_idle", busy2, 0);

        // Reset in the middle of a transfer
        req_data = 32'h00000055;
        req = 4'b0001;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("mr_gnt", gnt, 4'b0000);
        check("mr_busy", busy, 1);
        check("mr_wren", bus.bus_wren, 0);
        check("mr_rden", bus.bus_rden, 0);
        check("mr_addr", bus.bus_addr, 3'b010);
        tick();
        check("mr_hold_gnt", gnt, 4'b0000);
        reset = 1'b0;
        req = 4'b0000;
        tick();
        check("mr_init_wren", bus.bus_wren, 1);
        check("mr_init_addr", bus.bus_addr, 3'b000);
        check("mr_init_din", bus.bus_din, 8'h1A);
        check("mr_init_gnt", gnt, 4'b0000);
        tick();
        check("mr_idle_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameters SHALL be:
- PERIOD, 8'h1A, baud period written to the UART period register at init.
- TIMEOUT, 8'd255, maximum number of consecutive full-FIFO polls before a transfer is dropped.

REQ-002 Ports SHALL be:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  4  per-requester byte request; level, held until gnt or drop.
- req_data  input  32  requester i byte at [8i+7:8i]; held with req.
- cfg_we  input  1  one-cycle pulse requesting a period reprogram.
- cfg_period  input  8  new period, sampled when cfg_we=1.
- gnt  output  4  one-hot, one-cycle pulse: byte written to the UART.
- drop  output  1  one-cycle pulse: selected transfer abandoned on timeout.
- busy  output  1  high in every state except IDLE.
- bus_wren  output  1  UART register write strobe.
- bus_rden  output  1  UART register read strobe.
- bus_addr  output  3  UART register address (000 period, 001 TX, 011 control).
- bus_din  output  8  UART write data.
- bus_dout  input  8  UART read data; valid the cycle after bus_rden.

Function
REQ-003 All outputs SHALL be registered (Moore decode of the state register plus registered bus_din/bus_addr).
REQ-004 States SHALL be INIT, IDLE, CFG, POLL, CHECK, WRITE.
REQ-005 INIT SHALL drive bus_wren=1, bus_addr=000, bus_din=period_reg for one cycle, then go to IDLE.
REQ-006 cfg_we SHALL load period_reg from cfg_period and set cfg_pend in any state; a cfg_we in the same cycle as the CFG write SHALL leave cfg_pend set.
REQ-007 In IDLE with cfg_pend=1, the next state SHALL be CFG: bus_wren=1, addr=000, din=period_reg, and cfg_pend is cleared. CFG has priority over requests.
REQ-008 In IDLE with cfg_pend=0 and req!=0, the block SHALL select the round-robin winner (start at rr_ptr, ascending, wrap 3->0), latch sel, and go to POLL.
REQ-009 POLL SHALL drive bus_rden=1, bus_addr=011 for one cycle and go to CHECK.
REQ-010 CHECK SHALL sample bus_dout[0] (UART FIFO full):
- Full with poll_cnt<TIMEOUT: increment poll_cnt and go to POLL.
- Full with poll_cnt==TIMEOUT: pulse drop, go to IDLE, leave rr_ptr unchanged.
- Not full: register bus_din=req_data[sel], bus_addr=001 and go to WRITE.
REQ-011 WRITE SHALL assert bus_wren=1 and gnt[sel]=1 for exactly one cycle, set rr_ptr=sel+1 mod 4, clear poll_cnt, and return to IDLE.
REQ-012 If req[sel] deasserts in POLL or CHECK, the block SHALL return to IDLE with no write, no gnt, and rr_ptr unchanged.
REQ-013 Uncontended latency SHALL be fixed: req seen in IDLE at cycle N gives POLL N+1, CHECK N+2, WRITE/gnt N+3, IDLE N+4.
REQ-014 poll_cnt SHALL be an 8-bit counter, cleared on entry to POLL from IDLE, never wrapping.
REQ-015 bus_wren and bus_rden SHALL never be high in the same cycle; in IDLE both are 0 and bus_addr=010.

Reset
REQ-016 Reset SHALL force state=INIT, period_reg=PERIOD, cfg_pend=0, rr_ptr=0, sel=0, poll_cnt=0, gnt=0, drop=0, busy=1, bus_wren=0, bus_rden=0, bus_addr=010, bus_din=0.
REQ-017 Reset mid-transfer SHALL abort immediately with no gnt; the first cycle after release SHALL be INIT.

Verification
REQ-018 Release reset -> one cycle with bus_wren=1, addr=000, din=8'h1A, then IDLE with busy=0.
REQ-019 req=4'b0001, data 8'h55, dout[0]=0 -> rden at N+1, wren addr=001 din=8'h55 with gnt=0001 at N+3.
REQ-020 req=4'b1111 held continuously -> grant order 0,1,2,3,0; each gnt spaced 4 cycles apart.
REQ-021 dout[0]=1 for 3 polls then 0 -> 4 POLL/CHECK pairs, then a single write with gnt; with TIMEOUT=2 and full held -> drop pulses after the 3rd CHECK, with no wren at addr 001.
REQ-022 cfg_we with 8'h0D while req[2]=1 in IDLE -> CFG write (addr 000, din 8'h0D) precedes the POLL for requester 2.
REQ-023 req[1] dropped during CHECK -> return to IDLE with no gnt, and requester 1 keeps priority at the next arbitration.
